multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multicycle CPU control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback
//  over a shared memory with a ready handshake. Generalises the single-cycle controller
//  (parametrised opcode/funct/ALU widths, opcode map as parameters). Drives the multicycle
//  datapath; pcen replaces the single-cycle pcsrc AND gate.
// PARAMETERS
//  OP_W      5        opcode width
//  FN_W      4        funct width (R-type ALU select)
//  ALUCTL_W  4        alucontrol width; FN_W >= ALUCTL_W
//  OP_RTYPE  5'h00    R-type opcode
//  OP_LW     5'h01    load word
//  OP_SW     5'h02    store word
//  OP_BEQ    5'h03    branch if equal
//  OP_ADDI   5'h04    add immediate
//  OP_J      5'h05    jump
//  ALU_ADD   4'h0     alucontrol code for add
//  ALU_SUB   4'h1     alucontrol code for subtract
//  PERF_W    32       perf counter width (CTRL_PERF_EN only)
// PORTS
//  clk          in   1         rising-edge clock
//  reset_n      in   1         async active-low reset
//  op           in   OP_W      opcode from instruction register
//  funct        in   FN_W      funct from instruction register
//  zero         in   1         ALU zero flag
//  mem_ready    in   1         memory access completes this cycle
//  mem_req      out  1         memory access request (read or write)
//  iord         out  1         0=PC addresses memory, 1=ALUOut
//  memwrite     out  1         memory write strobe
//  irwrite      out  1         instruction register load
//  regwrite     out  1         register file write
//  regdst       out  1         1=rd, 0=rt destination
//  memtoreg     out  1         1=memory data, 0=ALUOut writeback
//  alusrca      out  1         0=PC, 1=regA
//  alusrcb      out  2         00=regB 01=const4 10=signimm 11=signimm<<2
//  pcsrc        out  2         00=ALU result 01=ALUOut 10=jump target
//  pcen         out  1         PC load = pcwrite | (branch & zero)
//  alucontrol   out  ALUCTL_W  ALU operation
//  illegal      out  1         1-cycle pulse: unknown opcode in DECODE
//  state        out  4         current state (debug)
// BEHAVIOUR
//  - States: FETCH DECODE MEMADR MEMRD MEMWB MEMWR EXEC ALUWB ADDIEX ADDIWB BRANCH JUMP.
//  - reset_n low: state=FETCH immediately; all strobes (memwrite irwrite regwrite pcen
//    illegal) forced 0 while asserted; other outputs 0. Reset mid-instruction aborts it.
//  - Outputs are combinational from state (plus mem_ready/zero where noted); default 0,
//    alucontrol default ALU_ADD.
//  - FETCH: mem_req=1 iord=0 alusrca=0 alusrcb=01 pcsrc=00; irwrite=pcen=mem_ready;
//    stay until mem_ready, then DECODE.
//  - DECODE: alusrca=0 alusrcb=11 (precompute branch target). Next by op: LW/SW->MEMADR,
//    RTYPE->EXEC, ADDI->ADDIEX, BEQ->BRANCH, J->JUMP; else illegal=1, ->FETCH.
//  - MEMADR: alusrca=1 alusrcb=10; ->MEMRD (LW) or MEMWR (SW).
//  - MEMRD: mem_req=1 iord=1; hold until mem_ready, then MEMWB.
//  - MEMWB: regwrite=1 memtoreg=1 regdst=0; ->FETCH.
//  - MEMWR: mem_req=1 iord=1 memwrite=1 held steady until mem_ready; then ->FETCH.
//  - EXEC: alusrca=1 alusrcb=00 alucontrol=funct[ALUCTL_W-1:0]; ->ALUWB.
//  - ALUWB: regwrite=1 regdst=1 memtoreg=0; ->FETCH.
//  - ADDIEX: alusrca=1 alusrcb=10 ALU_ADD; ->ADDIWB (regwrite=1 regdst=0); ->FETCH.
//  - BRANCH: alusrca=1 alusrcb=00 ALU_SUB pcsrc=01 pcen=zero; ->FETCH.
//  - JUMP: pcsrc=10 pcen=1; ->FETCH.
//  - Latency (mem_ready always 1): LW 5, SW 4, R/ADDI 4, BEQ 3, J 3 cycles.
//    Each mem_ready-low cycle in FETCH/MEMRD/MEMWR adds one cycle.
//  - op/funct sampled only in DECODE/EXEC; changes elsewhere ignored.
// CONFIGURATION
//  CTRL_PERF_EN defined: adds outputs cycle_count, instr_count (PERF_W each). Both reset
//    to 0; cycle_count +1 every cycle out of reset; instr_count +1 on each DECODE
//    cycle with legal op. Both wrap to 0 past all-ones.
//  Undefined: ports and counters absent; FSM identical.
// TESTING
//  1 reset_n low mid-MEMWR (memwrite=1) -> memwrite=0 same cycle, state=FETCH on release.
//  2 LW, mem_ready=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite+memtoreg in cycle 5 only.
//  3 SW, mem_ready low 3 cycles in MEMWR -> memwrite held 4 cycles, one write, then FETCH.
//  4 BEQ zero=1 -> pcen=1 pcsrc=01 in BRANCH; zero=0 -> pcen=0, next state FETCH.
//  5 R-type funct=4'h6 -> alucontrol=4'h6 in EXEC, regwrite+regdst in ALUWB.
//  6 op=5'h1F -> illegal=1 one cycle in DECODE, no strobes; CTRL_PERF_EN: instr_count unchanged.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Purpose : bundles the instruction fields, ALU flag, memory handshake and all
//           datapath control lines exchanged between the multicycle controller
//           and its datapath.
// Modports:
//   master - the controller: receives op/funct/zero/mem_ready, drives controls
//   slave  - the datapath: drives op/funct/zero/mem_ready, receives controls
// Optional: CTRL_PERF_EN adds the cycle_count / instr_count performance lines.
// -----------------------------------------------------------------------------
interface multicycle_controller_if #(
    parameter int OP_W     = 5,
    parameter int FN_W     = 4,
    parameter int ALUCTL_W = 4,
    parameter int PERF_W   = 32
);
    logic [OP_W-1:0]     op;
    logic [FN_W-1:0]     funct;
    logic                zero;
    logic                mem_ready;

    logic                mem_req;
    logic                iord;
    logic                memwrite;
    logic                irwrite;
    logic                regwrite;
    logic                regdst;
    logic                memtoreg;
    logic                alusrca;
    logic [1:0]          alusrcb;
    logic [1:0]          pcsrc;
    logic                pcen;
    logic [ALUCTL_W-1:0] alucontrol;
    logic                illegal;
    logic [3:0]          state;

`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0]   cycle_count;
    logic [PERF_W-1:0]   instr_count;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal, state,
               cycle_count, instr_count
    );
    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal, state,
               cycle_count, instr_count
    );
`else
    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal, state
    );
    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal, state
    );
`endif
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Purpose : Moore control FSM for a multicycle CPU sharing one memory for
//           instructions and data. Sequences fetch/decode/execute/memory/
//           writeback and waits on mem_ready for every memory access.
// Ports   :
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset; forces FETCH and zeroes outputs
//   bus      - multicycle_controller_if.master (instruction fields, zero flag,
//              mem_ready in; all datapath controls and debug state out)
// Optional: define CTRL_PERF_EN to add cycle_count / instr_count counters.
//
// State table:
//   FETCH  | read instruction at PC, PC+4, load IR on mem_ready
//   DECODE | read registers, precompute branch target, dispatch on op
//   MEMADR | compute load/store address
//   MEMRD  | read data memory until mem_ready
//   MEMWB  | write loaded data to rt
//   MEMWR  | write data memory until mem_ready
//   EXEC   | R-type ALU operation selected by funct
//   ALUWB  | write ALU result to rd
//   ADDIEX | add sign-extended immediate
//   ADDIWB | write ADDI result to rt
//   BRANCH | compare and conditionally load branch target
//   JUMP   | load jump target
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int                 OP_W     = 5,
    parameter int                 FN_W     = 4,
    parameter int                 ALUCTL_W = 4,
    parameter logic [OP_W-1:0]    OP_RTYPE = 5'h00,
    parameter logic [OP_W-1:0]    OP_LW    = 5'h01,
    parameter logic [OP_W-1:0]    OP_SW    = 5'h02,
    parameter logic [OP_W-1:0]    OP_BEQ   = 5'h03,
    parameter logic [OP_W-1:0]    OP_ADDI  = 5'h04,
    parameter logic [OP_W-1:0]    OP_J     = 5'h05,
    parameter logic [ALUCTL_W-1:0] ALU_ADD = 4'h0,
    parameter logic [ALUCTL_W-1:0] ALU_SUB = 4'h1,
    parameter int                 PERF_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    multicycle_controller_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t st;
    // op is only sampled in DECODE, so the load/store choice for MEMADR is kept here.
    logic   is_store;
    logic   op_legal;

    assign op_legal = (bus.op == OP_RTYPE) || (bus.op == OP_LW)   ||
                      (bus.op == OP_SW)    || (bus.op == OP_BEQ)  ||
                      (bus.op == OP_ADDI)  || (bus.op == OP_J);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st       <= S_FETCH;
            is_store <= 1'b0;
        end else begin
            case (st)
                S_FETCH:  if (bus.mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    is_store <= (bus.op == OP_SW);
                    if (bus.op == OP_LW || bus.op == OP_SW) st <= S_MEMADR;
                    else if (bus.op == OP_RTYPE)            st <= S_EXEC;
                    else if (bus.op == OP_ADDI)             st <= S_ADDIEX;
                    else if (bus.op == OP_BEQ)              st <= S_BRANCH;
                    else if (bus.op == OP_J)                st <= S_JUMP;
                    else                                    st <= S_FETCH;
                end
                S_MEMADR: st <= is_store ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (bus.mem_ready) st <= S_MEMWB;
                S_MEMWR:  if (bus.mem_ready) st <= S_FETCH;
                S_EXEC:   st <= S_ALUWB;
                S_ADDIEX: st <= S_ADDIWB;
                default:  st <= S_FETCH;
            endcase
        end
    end

    // Outputs are decoded from state; reset_n gates them so that strobes drop
    // in the same cycle the reset is asserted, not at the next edge.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regwrite   = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.pcen       = 1'b0;
        bus.alucontrol = ALU_ADD;
        bus.illegal    = 1'b0;
        bus.state      = st;
        if (reset_n) begin
            case (st)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.alusrcb = 2'b01;
                    bus.irwrite = bus.mem_ready;
                    bus.pcen    = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alusrcb = 2'b11;
                    bus.illegal = !op_legal;
                end
                S_MEMADR: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                end
                S_MEMWB: begin
                    bus.regwrite = 1'b1;
                    bus.memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_req  = 1'b1;
                    bus.iord     = 1'b1;
                    bus.memwrite = 1'b1;
                end
                S_EXEC: begin
                    bus.alusrca    = 1'b1;
                    bus.alucontrol = bus.funct[ALUCTL_W-1:0];
                end
                S_ALUWB: begin
                    bus.regwrite = 1'b1;
                    bus.regdst   = 1'b1;
                end
                S_ADDIEX: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                end
                S_ADDIWB: bus.regwrite = 1'b1;
                S_BRANCH: begin
                    bus.alusrca    = 1'b1;
                    bus.alucontrol = ALU_SUB;
                    bus.pcsrc      = 2'b01;
                    bus.pcen       = bus.zero;
                end
                S_JUMP: begin
                    bus.pcsrc = 2'b10;
                    bus.pcen  = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0] cycle_cnt;
    logic [PERF_W-1:0] instr_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + PERF_W'(1);
            if (st == S_DECODE && op_legal) instr_cnt <= instr_cnt + PERF_W'(1);
        end
    end

    assign bus.cycle_count = cycle_cnt;
    assign bus.instr_count = instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam logic [4:0] OP_RTYPE = 5'h00;
    localparam logic [4:0] OP_LW    = 5'h01;
    localparam logic [4:0] OP_SW    = 5'h02;
    localparam logic [4:0] OP_BEQ   = 5'h03;
    localparam logic [4:0] OP_ADDI  = 5'h04;
    localparam logic [4:0] OP_J     = 5'h05;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       illegal;
        logic [3:0] alucontrol;
    } ctl_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    logic [31:0] exp_cyc;
    logic [31:0] exp_instr;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t observed();
        ctl_t o;
        o = {bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.regwrite,
             bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc,
             bus.pcen, bus.illegal, bus.alucontrol};
        return o;
    endfunction

    task automatic check(input string tag, input ctl_t exp);
        ctl_t obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
`ifdef CTRL_PERF_EN
        checks++;
        assert (bus.cycle_count === exp_cyc) else begin
            errors++;
            $error("FAIL %s cycle_count: observed %0d expected %0d", tag, bus.cycle_count, exp_cyc);
        end
        checks++;
        assert (bus.instr_count === exp_instr) else begin
            errors++;
            $error("FAIL %s instr_count: observed %0d expected %0d", tag, bus.instr_count, exp_instr);
        end
`endif
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance.
    task automatic cycle(input string tag, input logic [4:0] o, input logic [3:0] f,
                         input logic z, input logic r, input ctl_t exp, input bit counts);
        bus.op        = o;
        bus.funct     = f;
        bus.zero      = z;
        bus.mem_ready = r;
        @(negedge clk);
        check(tag, exp);
        @(posedge clk);
        #1;
        exp_cyc = exp_cyc + 32'd1;
        if (counts) exp_instr = exp_instr + 32'd1;
    endtask

    function automatic logic [4:0] rop();
        return 5'($urandom);
    endfunction
    function automatic logic [3:0] rfn();
        return 4'($urandom);
    endfunction
    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // Expected control pattern for every cycle of one instruction, derived
    // from the instruction class plus the number of memory stall cycles.
    task automatic run_instr(input string tag, input logic [4:0] op, input logic [3:0] funct,
                             input logic z, input int fetch_wait, input int mem_wait);
        ctl_t e;
        bit   legal;
        legal = (op <= OP_J);
        for (int i = 0; i < fetch_wait; i++) begin
            e = '0; e.mem_req = 1; e.alusrcb = 2'b01;
            cycle({tag, ".fetch_wait"}, rop(), rfn(), rbit(), 1'b0, e, 0);
        end
        e = '0; e.mem_req = 1; e.alusrcb = 2'b01; e.irwrite = 1; e.pcen = 1;
        cycle({tag, ".fetch"}, rop(), rfn(), rbit(), 1'b1, e, 0);
        e = '0; e.alusrcb = 2'b11; e.illegal = !legal;
        cycle({tag, ".decode"}, op, rfn(), rbit(), rbit(), e, legal);
        if (op == OP_LW || op == OP_SW) begin
            e = '0; e.alusrca = 1; e.alusrcb = 2'b10;
            cycle({tag, ".memadr"}, rop(), rfn(), rbit(), rbit(), e, 0);
            e = '0; e.mem_req = 1; e.iord = 1; e.memwrite = (op == OP_SW);
            for (int i = 0; i < mem_wait; i++)
                cycle({tag, ".mem_wait"}, rop(), rfn(), rbit(), 1'b0, e, 0);
            cycle({tag, ".mem"}, rop(), rfn(), rbit(), 1'b1, e, 0);
            if (op == OP_LW) begin
                e = '0; e.regwrite = 1; e.memtoreg = 1;
                cycle({tag, ".memwb"}, rop(), rfn(), rbit(), rbit(), e, 0);
            end
        end else if (op == OP_RTYPE) begin
            e = '0; e.alusrca = 1; e.alucontrol = funct;
            cycle({tag, ".exec"}, rop(), funct, rbit(), rbit(), e, 0);
            e = '0; e.regwrite = 1; e.regdst = 1;
            cycle({tag, ".aluwb"}, rop(), rfn(), rbit(), rbit(), e, 0);
        end else if (op == OP_ADDI) begin
            e = '0; e.alusrca = 1; e.alusrcb = 2'b10;
            cycle({tag, ".addiex"}, rop(), rfn(), rbit(), rbit(), e, 0);
            e = '0; e.regwrite = 1;
            cycle({tag, ".addiwb"}, rop(), rfn(), rbit(), rbit(), e, 0);
        end else if (op == OP_BEQ) begin
            e = '0; e.alusrca = 1; e.alucontrol = 4'h1; e.pcsrc = 2'b01; e.pcen = z;
            cycle({tag, ".branch"}, rop(), rfn(), z, rbit(), e, 0);
        end else if (op == OP_J) begin
            e = '0; e.pcsrc = 2'b10; e.pcen = 1;
            cycle({tag, ".jump"}, rop(), rfn(), rbit(), rbit(), e, 0);
        end
    endtask

    initial begin
        ctl_t e;
        logic [4:0] op;
        checks    = 0;
        errors    = 0;
        exp_cyc   = '0;
        exp_instr = '0;
        reset_n   = 1'b0;
        bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("reset_outputs", ctl_t'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset asserted in the middle of a stalled store.
        e = '0; e.mem_req = 1; e.alusrcb = 2'b01; e.irwrite = 1; e.pcen = 1;
        cycle("rst.fetch", rop(), rfn(), 1'b0, 1'b1, e, 0);
        e = '0; e.alusrcb = 2'b11;
        cycle("rst.decode", OP_SW, rfn(), 1'b0, 1'b1, e, 1);
        e = '0; e.alusrca = 1; e.alusrcb = 2'b10;
        cycle("rst.memadr", rop(), rfn(), 1'b0, 1'b1, e, 0);
        e = '0; e.mem_req = 1; e.iord = 1; e.memwrite = 1;
        cycle("rst.memwr", rop(), rfn(), 1'b0, 1'b0, e, 0);
        bus.mem_ready = 1'b0;
        #2 reset_n = 1'b0;
        exp_cyc   = '0;
        exp_instr = '0;
        #1 check("rst.mid_memwr", ctl_t'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;

        run_instr("after_rst_lw", OP_LW, 4'h0, 1'b0, 0, 0);
        run_instr("lw_ready", OP_LW, rfn(), 1'b0, 0, 0);
        run_instr("sw_stall3", OP_SW, rfn(), 1'b0, 0, 3);
        run_instr("beq_taken", OP_BEQ, rfn(), 1'b1, 0, 0);
        run_instr("beq_not", OP_BEQ, rfn(), 1'b0, 0, 0);
        run_instr("rtype_f6", OP_RTYPE, 4'h6, 1'b0, 0, 0);
        run_instr("addi", OP_ADDI, rfn(), 1'b0, 0, 0);
        run_instr("jump", OP_J, rfn(), 1'b0, 0, 0);
        run_instr("illegal_1f", 5'h1F, rfn(), 1'b0, 0, 0);
        run_instr("lw_stalls", OP_LW, rfn(), 1'b0, 2, 2);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 99) < 85) op = 5'($urandom_range(0, 5));
            else                            op = 5'($urandom_range(6, 31));
            run_instr("rand", op, rfn(), rbit(),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
